// File: rtl/dma_desc_sched_if.sv
// Handshake bundle between dma_desc_sched, the CSR block and the read/write streamers.
// The loop_mode signal is present only when DMA_DESC_LOOP_EN is defined.
interface dma_desc_sched_if #(
  parameter int NUM_DESC    = 4,
  parameter int BYTES_WIDTH = 32
);
  localparam int IDX_W = $clog2(NUM_DESC);

  logic                            dma_go;
  logic                            dma_abort;
  logic [NUM_DESC-1:0]             desc_en;
  logic [NUM_DESC*BYTES_WIDTH-1:0] desc_bytes;
  logic                            rd_str_valid;
  logic [IDX_W-1:0]                rd_str_idx;
  logic                            rd_str_done;
  logic                            wr_str_valid;
  logic [IDX_W-1:0]                wr_str_idx;
  logic                            wr_str_done;
  logic                            axi_err;
  logic                            rd_idle;
  logic                            wr_idle;
  logic                            status_done;
  logic                            status_error;
  logic                            dma_active;
  logic [IDX_W-1:0]                cur_desc;
  logic [IDX_W:0]                  desc_done_cnt;
`ifdef DMA_DESC_LOOP_EN
  logic                            loop_mode;
`endif

  modport master (
`ifdef DMA_DESC_LOOP_EN
    input  loop_mode,
`endif
    input  dma_go, dma_abort, desc_en, desc_bytes,
    input  rd_str_done, wr_str_done, axi_err, rd_idle, wr_idle,
    output rd_str_valid, rd_str_idx, wr_str_valid, wr_str_idx,
    output status_done, status_error, dma_active, cur_desc, desc_done_cnt
  );

  modport slave (
`ifdef DMA_DESC_LOOP_EN
    output loop_mode,
`endif
    output dma_go, dma_abort, desc_en, desc_bytes,
    output rd_str_done, wr_str_done, axi_err, rd_idle, wr_idle,
    input  rd_str_valid, rd_str_idx, wr_str_valid, wr_str_idx,
    input  status_done, status_error, dma_active, cur_desc, desc_done_cnt
  );
endinterface

// File: rtl/dma_desc_sched.sv
// Multi-descriptor DMA sequencer: walks enabled descriptors in ascending order, dispatches
// each to the read/write streamers, drains on abort/error. DMA_DESC_LOOP_EN adds loop mode.
module dma_desc_sched #(
  parameter int NUM_DESC    = 4,
  parameter int BYTES_WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  dma_desc_sched_if.master bus
);
  localparam int IDX_W = $clog2(NUM_DESC);

  typedef enum logic [2:0] {IDLE, CFG, RUN, DRAIN, DONE} state_t;

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       cur, cur_nxt;
  logic [IDX_W-1:0]       next_idx, first_idx;
  logic                   next_found, first_found;
  logic                   rd_seen, rd_seen_nxt, wr_seen, wr_seen_nxt;
  logic                   done_q, done_nxt, err_q, err_nxt;
  logic [IDX_W:0]         cnt, cnt_nxt;
  logic [BYTES_WIDTH-1:0] cur_bytes;
  logic                   rd_hit, wr_hit, loop_wrap;

  assign cur_bytes = bus.desc_bytes[int'(cur)*BYTES_WIDTH +: BYTES_WIDTH];
  assign rd_hit    = rd_seen | bus.rd_str_done;
  assign wr_hit    = wr_seen | bus.wr_str_done;

`ifdef DMA_DESC_LOOP_EN
  assign loop_wrap = bus.loop_mode & first_found;
`else
  assign loop_wrap = 1'b0;
`endif

  // Scanning downward leaves the lowest qualifying index in each result.
  always_comb begin
    next_found  = 1'b0;
    next_idx    = '0;
    first_found = 1'b0;
    first_idx   = '0;
    for (int k = NUM_DESC - 1; k >= 0; k--) begin
      if (bus.desc_en[k]) begin
        first_found = 1'b1;
        first_idx   = IDX_W'(k);
        if (k > int'(cur)) begin
          next_found = 1'b1;
          next_idx   = IDX_W'(k);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= '0;
      rd_seen <= 1'b0;
      wr_seen <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      cur     <= cur_nxt;
      rd_seen <= rd_seen_nxt;
      wr_seen <= wr_seen_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
      cnt     <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cur_nxt     = cur;
    rd_seen_nxt = rd_hit;
    wr_seen_nxt = wr_hit;
    done_nxt    = done_q;
    err_nxt     = err_q;
    cnt_nxt     = cnt;
    case (state)
      IDLE, DONE: begin
        if (bus.dma_go) begin
          done_nxt = 1'b0;
          err_nxt  = 1'b0;
          cnt_nxt  = '0;
          if (!first_found) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            cur_nxt   = first_idx;
            state_nxt = CFG;
          end
        end
      end
      CFG: begin
        rd_seen_nxt = 1'b0;
        wr_seen_nxt = 1'b0;
        if (bus.axi_err || cur_bytes == '0) err_nxt = 1'b1;
        if (bus.axi_err || bus.dma_abort || cur_bytes == '0) state_nxt = DRAIN;
        else                                                 state_nxt = RUN;
      end
      RUN: begin
        // A completion that coincides with abort/error is still counted before draining.
        if (rd_hit && wr_hit) cnt_nxt = cnt + 1'b1;
        if (bus.axi_err) begin
          err_nxt   = 1'b1;
          state_nxt = DRAIN;
        end else if (bus.dma_abort) begin
          state_nxt = DRAIN;
        end else if (rd_hit && wr_hit) begin
          if (next_found) begin
            cur_nxt   = next_idx;
            state_nxt = CFG;
          end else if (loop_wrap) begin
            cur_nxt   = first_idx;
            state_nxt = CFG;
          end else begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (bus.rd_idle && bus.wr_idle) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.rd_str_valid  = (state == RUN);
  assign bus.wr_str_valid  = (state == RUN);
  assign bus.rd_str_idx    = cur;
  assign bus.wr_str_idx    = cur;
  assign bus.cur_desc      = cur;
  assign bus.status_done   = done_q;
  assign bus.status_error  = err_q;
  assign bus.desc_done_cnt = cnt;
  assign bus.dma_active    = (state == CFG) || (state == RUN) || (state == DRAIN);
endmodule
